// File: rtl/free_list.sv
// Physical register free list: circular buffer of PREGS-AREGS IDs with one head checkpoint.
// Define FREE_LIST_BYPASS_EN to let a freed register be offered in the same cycle when the list is empty.
module free_list #(
   parameter int PREGS = 128,
   parameter int AREGS = 32,
   parameter int PW    = 7
) (
   input  logic          clk,
   input  logic          reset,
   output logic          alloc_valid,
   output logic [PW-1:0] alloc_preg,
   input  logic          alloc_ready,
   input  logic          free_valid,
   input  logic [PW-1:0] free_preg,
   input  logic          ckpt_save,
   input  logic          recover,
   output logic [PW:0]   free_count,
   output logic          err_overflow
);

   localparam int DEPTH = PREGS - AREGS;
   localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PW-1:0] fl_buf [DEPTH];
   // pointers are {phase, index}
   logic [IW:0]   head_q, tail_q, ckpt_q;
   logic [IW:0]   head_alloc;
   logic          bypass, do_alloc, do_free, full, empty;

   function automatic logic [IW:0] ptr_inc(input logic [IW:0] p);
      if (p[IW-1:0] == IW'(DEPTH - 1))
         return {~p[IW], {IW{1'b0}}};
      else
         return {p[IW], p[IW-1:0] + IW'(1)};
   endfunction

   always_comb begin
      free_count = '0;
      if (tail_q[IW] != head_q[IW] && tail_q[IW-1:0] == head_q[IW-1:0])
         free_count = (PW+1)'(DEPTH);
      else if (tail_q[IW-1:0] >= head_q[IW-1:0])
         free_count = (PW+1)'(tail_q[IW-1:0] - head_q[IW-1:0]);
      else
         free_count = (PW+1)'(DEPTH - int'(head_q[IW-1:0]) + int'(tail_q[IW-1:0]));
   end

   assign empty = (free_count == '0);
   assign full  = (free_count == (PW+1)'(DEPTH));

`ifdef FREE_LIST_BYPASS_EN
   assign bypass = empty && free_valid;
`else
   assign bypass = 1'b0;
`endif

   assign alloc_valid = !empty || bypass;
   assign alloc_preg  = bypass ? free_preg : fl_buf[head_q[IW-1:0]];

   // a bypassed register goes straight to rename and never touches the buffer
   assign do_alloc   = alloc_valid && alloc_ready && !recover && !bypass;
   assign do_free    = free_valid && !bypass && (!full || do_alloc);
   assign head_alloc = do_alloc ? ptr_inc(head_q) : head_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++)
            fl_buf[i] <= PW'(AREGS + i);
         head_q       <= '0;
         tail_q       <= {1'b1, {IW{1'b0}}};
         ckpt_q       <= '0;
         err_overflow <= 1'b0;
      end else begin
         if (do_free) begin
            fl_buf[tail_q[IW-1:0]] <= free_preg;
            tail_q                 <= ptr_inc(tail_q);
         end
         if (free_valid && !bypass && !do_free)
            err_overflow <= 1'b1;
         if (recover) begin
            head_q <= ckpt_q;
         end else begin
            head_q <= head_alloc;
            if (ckpt_save)
               ckpt_q <= head_alloc;
         end
      end
   end

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed scenarios plus randomized traffic
// compared against an unbounded-index queue model of the free list.
module tb_free_list;

   localparam int PREGS = 128;
   localparam int AREGS = 32;
   localparam int PW    = 7;
   localparam int DEPTH = PREGS - AREGS;
`ifdef FREE_LIST_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          alloc_ready = 1'b0;
   logic          free_valid = 1'b0;
   logic [PW-1:0] free_preg = '0;
   logic          ckpt_save = 1'b0;
   logic          recover = 1'b0;
   logic          alloc_valid;
   logic [PW-1:0] alloc_preg;
   logic [PW:0]   free_count;
   logic          err_overflow;

   free_list #(.PREGS(PREGS), .AREGS(AREGS), .PW(PW)) dut (
      .clk(clk), .reset(reset),
      .alloc_valid(alloc_valid), .alloc_preg(alloc_preg), .alloc_ready(alloc_ready),
      .free_valid(free_valid), .free_preg(free_preg),
      .ckpt_save(ckpt_save), .recover(recover),
      .free_count(free_count), .err_overflow(err_overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // model: absolute (never wrapping) allocation/free positions over a sparse store
   int m_head, m_tail, m_ckpt;
   bit m_err;
   int mem [int];

   function automatic int m_cnt();
      return m_tail - m_head;
   endfunction

   function automatic bit m_byp();
      return BYP && (m_cnt() == 0) && free_valid;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mem.delete();
      for (int i = 0; i < DEPTH; i++) mem[i] = AREGS + i;
      m_head = 0;
      m_tail = DEPTH;
      m_ckpt = 0;
      m_err  = 1'b0;
   endtask

   task automatic drive(input bit ar, input bit fv, input logic [PW-1:0] fp,
                        input bit cs, input bit rec, input bit rst_n);
      bit ev;
      alloc_ready = ar;
      free_valid  = fv;
      free_preg   = fp;
      ckpt_save   = cs;
      recover     = rec;
      reset       = rst_n;
      #3;
      if (rst_n) begin
         ev = (m_cnt() != 0) || m_byp();
         chk("alloc_valid", 32'(alloc_valid), 32'(ev));
         chk("free_count", 32'(free_count), 32'(m_cnt()));
         chk("err_overflow", 32'(err_overflow), 32'(m_err));
         if (ev)
            chk("alloc_preg", 32'(alloc_preg), m_byp() ? 32'(fp) : 32'(mem[m_head]));
      end
   endtask

   task automatic tick();
      bit byp, valid, alloc, fok;
      int nh;
      @(posedge clk);
      if (!reset) begin
         model_reset();
      end else begin
         byp   = m_byp();
         valid = (m_cnt() != 0) || byp;
         alloc = valid && alloc_ready && !recover && !byp;
         fok   = free_valid && !byp && ((m_cnt() < DEPTH) || alloc);
         if (free_valid && !byp && !fok) m_err = 1'b1;
         nh = m_head + (alloc ? 1 : 0);
         if (fok) begin
            mem[m_tail] = free_preg;
            m_tail++;
         end
         if (recover) m_head = m_ckpt;
         else begin
            if (ckpt_save) m_ckpt = nh;
            m_head = nh;
         end
      end
      #1;
   endtask

   task automatic cyc(input bit ar, input bit fv, input logic [PW-1:0] fp,
                      input bit cs, input bit rec, input bit rst_n);
      drive(ar, fv, fp, cs, rec, rst_n);
      tick();
   endtask

   task automatic do_reset();
      cyc(0, 0, '0, 0, 0, 0);
   endtask

   initial begin
      int lim;
      bit ar, fv, cs, rec, rn;
      model_reset();
      do_reset();
      do_reset();

      // post-reset outputs
      drive(0, 0, '0, 0, 0, 1);
      chk("rst_valid", 32'(alloc_valid), 32'd1);
      chk("rst_preg", 32'(alloc_preg), 32'(AREGS));
      chk("rst_count", 32'(free_count), 32'(DEPTH));
      chk("rst_err", 32'(err_overflow), 32'd0);
      tick();

      // drain: 32..127 in order, then empty
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 0, '0, 0, 0, 1);
         chk("drain_preg", 32'(alloc_preg), 32'(AREGS + i));
         tick();
      end
      drive(0, 0, '0, 0, 0, 1);
      chk("drained_valid", 32'(alloc_valid), 32'd0);
      chk("drained_count", 32'(free_count), 32'd0);
      tick();

      // free p40 into the empty list
      if (BYP) begin
         drive(1, 1, 7'd40, 0, 0, 1);
         chk("byp_valid", 32'(alloc_valid), 32'd1);
         chk("byp_preg", 32'(alloc_preg), 32'd40);
         tick();
         drive(0, 0, '0, 0, 0, 1);
         chk("byp_count", 32'(free_count), 32'd0);
         tick();
      end else begin
         drive(0, 1, 7'd40, 0, 0, 1);
         chk("nobyp_same_valid", 32'(alloc_valid), 32'd0);
         tick();
         drive(1, 0, '0, 0, 0, 1);
         chk("nobyp_next_valid", 32'(alloc_valid), 32'd1);
         chk("nobyp_next_preg", 32'(alloc_preg), 32'd40);
         tick();
         drive(0, 0, '0, 0, 0, 1);
         chk("nobyp_count", 32'(free_count), 32'd0);
         tick();
      end

      // overflow while full
      do_reset();
      cyc(0, 1, 7'd5, 0, 0, 1);
      drive(0, 0, '0, 0, 0, 1);
      chk("ovf_err", 32'(err_overflow), 32'd1);
      chk("ovf_count", 32'(free_count), 32'(DEPTH));
      chk("ovf_preg", 32'(alloc_preg), 32'd32);
      tick();

      // simultaneous alloc+free at full is accepted
      do_reset();
      cyc(1, 1, 7'd3, 0, 0, 1);
      drive(0, 0, '0, 0, 0, 1);
      chk("full_swap_err", 32'(err_overflow), 32'd0);
      chk("full_swap_count", 32'(free_count), 32'(DEPTH));
      tick();

      // checkpoint and recover
      do_reset();
      cyc(1, 0, '0, 1, 0, 1);
      cyc(1, 0, '0, 0, 0, 1);
      cyc(1, 0, '0, 0, 0, 1);
      cyc(1, 0, '0, 0, 1, 1);
      drive(0, 0, '0, 0, 0, 1);
      chk("recover_preg", 32'(alloc_preg), 32'd33);
      chk("recover_count", 32'(free_count), 32'(DEPTH - 1));
      tick();

      // alloc+free at count 10: p7 comes out behind the older entries
      do_reset();
      for (int i = 0; i < DEPTH - 10; i++) cyc(1, 0, '0, 0, 0, 1);
      cyc(1, 1, 7'd7, 0, 0, 1);
      drive(0, 0, '0, 0, 0, 1);
      chk("swap_count", 32'(free_count), 32'd10);
      tick();
      for (int i = 0; i < 9; i++) cyc(1, 0, '0, 0, 0, 1);
      drive(1, 0, '0, 0, 0, 1);
      chk("swap_p7_last", 32'(alloc_preg), 32'd7);
      tick();

      // reset wins over recover+free+alloc
      cyc(1, 0, '0, 1, 0, 1);
      cyc(1, 1, 7'd9, 0, 1, 0);
      drive(0, 0, '0, 0, 0, 1);
      chk("midrst_valid", 32'(alloc_valid), 32'd1);
      chk("midrst_preg", 32'(alloc_preg), 32'(AREGS));
      chk("midrst_count", 32'(free_count), 32'(DEPTH));
      chk("midrst_err", 32'(err_overflow), 32'd0);
      tick();

      // randomized traffic; frees limited so no live entry is ever overwritten
      for (int n = 0; n < 3000; n++) begin
         ar  = ($urandom_range(0, 99) < 55);
         lim = (m_head < m_ckpt) ? m_head : m_ckpt;
         fv  = ($urandom_range(0, 99) < 50) && (m_tail + 1 - lim <= DEPTH);
         cs  = ($urandom_range(0, 7) == 0);
         rec = ($urandom_range(0, 15) == 0);
         rn  = ($urandom_range(0, 499) != 0);
         cyc(ar, fv, PW'($urandom_range(0, PREGS - 1)), cs, rec, rn);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
